// File: rtl/wf8_pkg.sv
// Shared WF8 data-RAM constants and the clear/run state type.
package wf8_pkg;
    localparam int WF8_ADDR_WIDTH = 8;
    localparam int WF8_DATA_WIDTH = 8;
    localparam int RDW_NEW_DATA   = 1;
    localparam int RDW_OLD_DATA   = 0;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ram_state_t;
endpackage

// File: rtl/ram_read_port.sv
// One read port: registered data/valid with optional write-first bypass; 1-cycle latency.
// No backpressure: a read is taken whenever accept_i and rd_en_i are high.
module ram_read_port
    import wf8_pkg::*;
#(
    parameter int ADDR_WIDTH = WF8_ADDR_WIDTH,
    parameter int DATA_WIDTH = WF8_DATA_WIDTH,
    parameter int RDW_MODE   = RDW_NEW_DATA
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  accept_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_dat_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o
);
    localparam bit BYPASS = (RDW_MODE != RDW_OLD_DATA);

    logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;
    logic                  rd_valid_d, rd_valid_q;
    logic                  hit;

    // wr_en_i is already qualified by the top, so a hit only forwards real writes.
    assign hit = BYPASS && wr_en_i && (wr_addr_i == rd_addr_i);

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (accept_i && rd_en_i) begin
            rd_valid_d = 1'b1;
            rd_data_d  = hit ? wr_data_i : mem_dat_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
endmodule

// File: rtl/ram_mp.sv
// Multi-read, single-write RAM with a post-reset zeroing sweep; 1-cycle read latency.
// No backpressure: requests are accepted only while ready is high.
module ram_mp
    import wf8_pkg::*;
#(
    parameter int ADDR_WIDTH     = WF8_ADDR_WIDTH,
    parameter int DATA_WIDTH     = WF8_DATA_WIDTH,
    parameter int READ_PORTS     = 2,
    parameter int RDW_MODE       = RDW_NEW_DATA,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [READ_PORTS-1:0]            rd_en,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [READ_PORTS-1:0]            rd_valid,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic                             ready
);
    localparam int         DEPTH       = 2 ** ADDR_WIDTH;
    localparam ram_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    ram_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_ptr_q, clear_ptr_d;
    logic                  ready_q, ready_d;
    logic                  accept;
    logic                  wr_acc;

    assign accept = ready_q && (state_q == RUN);
    assign wr_acc = accept && wr_en;

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        if (state_q == CLEAR) begin
            clear_ptr_d = clear_ptr_q + ADDR_WIDTH'(1);
            if (clear_ptr_q == '1) begin
                state_d = RUN;
            end
        end
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RESET_STATE;
            clear_ptr_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            ready_q     <= ready_d;
        end
    end

    // Storage has no reset; the sweep is the only way it gets zeroed.
    always_ff @(posedge clk) begin
        if (reset && (state_q == CLEAR)) begin
            mem_q[clear_ptr_q] <= '0;
        end else if (wr_acc) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        assign addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

        ram_read_port #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .RDW_MODE   (RDW_MODE)
        ) u_port (
            .clk        (clk),
            .reset      (reset),
            .accept_i   (accept),
            .rd_en_i    (rd_en[i]),
            .rd_addr_i  (addr),
            .mem_dat_i  (mem_q[addr]),
            .wr_en_i    (wr_acc),
            .wr_addr_i  (wr_addr),
            .wr_data_i  (wr_data),
            .rd_data_o  (rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .rd_valid_o (rd_valid[i])
        );
    end

    assign ready = ready_q;
endmodule

// File: tb/tb_ram_mp.sv
// Scoreboard bench for ram_mp across four parameter sets sharing clock and reset.
module tb_ram_mp;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // u_a: defaults (8b addr, 8b data, 2 ports, new-data bypass, clear sweep)
    logic [1:0]  rd_en_a = '0;  logic [15:0] rd_addr_a = '0;
    logic [15:0] rd_data_a;     logic [1:0]  rd_valid_a;
    logic        wr_en_a = 1'b0; logic [7:0] wr_addr_a = '0; logic [7:0] wr_data_a = '0;
    logic        ready_a;
    // u_b: old-data read-during-write
    logic [1:0]  rd_en_b = '0;  logic [15:0] rd_addr_b = '0;
    logic [15:0] rd_data_b;     logic [1:0]  rd_valid_b;
    logic        wr_en_b = 1'b0; logic [7:0] wr_addr_b = '0; logic [7:0] wr_data_b = '0;
    logic        ready_b;
    // u_c: 4b addr, 16b data, 4 ports
    logic [3:0]  rd_en_c = '0;  logic [15:0] rd_addr_c = '0;
    logic [63:0] rd_data_c;     logic [3:0]  rd_valid_c;
    logic        wr_en_c = 1'b0; logic [3:0] wr_addr_c = '0; logic [15:0] wr_data_c = '0;
    logic        ready_c;
    // u_d: no clear sweep
    logic [0:0]  rd_en_d = '0;  logic [3:0]  rd_addr_d = '0;
    logic [7:0]  rd_data_d;     logic [0:0]  rd_valid_d;
    logic        wr_en_d = 1'b0; logic [3:0] wr_addr_d = '0; logic [7:0] wr_data_d = '0;
    logic        ready_d;

    ram_mp u_a (.clk(clk), .reset(rst_n), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
                .rd_valid(rd_valid_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .ready(ready_a));
    ram_mp #(.RDW_MODE(0)) u_b (.clk(clk), .reset(rst_n), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
                .rd_valid(rd_valid_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .ready(ready_b));
    ram_mp #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .READ_PORTS(4)) u_c (.clk(clk), .reset(rst_n), .rd_en(rd_en_c),
                .rd_addr(rd_addr_c), .rd_data(rd_data_c), .rd_valid(rd_valid_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c),
                .wr_data(wr_data_c), .ready(ready_c));
    ram_mp #(.ADDR_WIDTH(4), .READ_PORTS(1), .CLEAR_ON_RESET(0)) u_d (.clk(clk), .reset(rst_n), .rd_en(rd_en_d),
                .rd_addr(rd_addr_d), .rd_data(rd_data_d), .rd_valid(rd_valid_d), .wr_en(wr_en_d), .wr_addr(wr_addr_d),
                .wr_data(wr_data_d), .ready(ready_d));

    typedef struct packed {
        logic [1:0]  inst;
        logic [1:0]  port;
        logic [15:0] dat;
    } exp_t;

    exp_t  sbq[$];
    string nmq[$];

    task automatic push(input int inst, input int port, input logic [15:0] dat, input string name);
        exp_t e;
        e.inst = 2'(inst);
        e.port = 2'(port);
        e.dat  = dat;
        sbq.push_back(e);
        nmq.push_back(name);
    endtask

    function automatic logic [16:0] obs(input int inst, input int port);
        logic [16:0] r;
        r = '0;
        case (inst)
            0:       r = {rd_valid_a[port], 8'h00, rd_data_a[port*8 +: 8]};
            1:       r = {rd_valid_b[port], 8'h00, rd_data_b[port*8 +: 8]};
            2:       r = {rd_valid_c[port], rd_data_c[port*16 +: 16]};
            default: r = {rd_valid_d[0], 8'h00, rd_data_d};
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int   edge_a = -1, edge_b = -1, edge_c = -1, edge_d = -1;
        logic viol   = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (ready_a !== 1'b0 || rd_valid_a !== 2'b00 || rd_data_a !== 16'h0) begin
            bad++;
            $display("FAIL reset_a: ready=%b valid=%b data=%h, want 0 00 0000", ready_a, rd_valid_a, rd_data_a);
        end
        total++;
        if (ready_c !== 1'b0 || rd_valid_c !== 4'h0 || rd_data_c !== 64'h0) begin
            bad++;
            $display("FAIL reset_c: ready=%b valid=%b data=%h, want all 0", ready_c, rd_valid_c, rd_data_c);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rd_en_a = 2'b11; rd_addr_a = 16'h3000;
        wr_en_a = 1'b1;  wr_addr_a = 8'h30; wr_data_a = 8'h7E;
        for (int n = 1; n <= 300 && edge_a < 0; n++) begin
            step();
            if (rd_valid_a !== 2'b00 || rd_data_a !== 16'h0) viol = 1'b1;
            if (ready_a === 1'b1) begin
                edge_a = n; rd_en_a = '0; wr_en_a = 1'b0;
            end
            if (ready_b === 1'b1 && edge_b < 0) edge_b = n;
            if (ready_c === 1'b1 && edge_c < 0) edge_c = n;
            if (ready_d === 1'b1 && edge_d < 0) edge_d = n;
        end
        total++;
        if (edge_a !== 256) begin bad++; $display("FAIL sweep_len_a: ready after %0d edges, want 256", edge_a); end
        total++;
        if (edge_b !== 256) begin bad++; $display("FAIL sweep_len_b: ready after %0d edges, want 256", edge_b); end
        total++;
        if (edge_c !== 16) begin bad++; $display("FAIL sweep_len_c: ready after %0d edges, want 16", edge_c); end
        total++;
        if (edge_d !== 1) begin bad++; $display("FAIL noclear_ready: ready after %0d edges, want 1", edge_d); end
        total++;
        if (viol !== 1'b0) begin bad++; $display("FAIL sweep_quiet: read output moved during sweep=%b, want 0", viol); end
    endtask

    task automatic test_clear_reads();
        exp_t e; string nm; logic [16:0] o;
        for (int r = 0; r < 2; r++) begin
            rd_en_a   = 2'b11;
            rd_addr_a = (r == 0) ? 16'h7F00 : 16'h30FF;
            push(0, 0, 16'h0, (r == 0) ? "clr_0x00" : "clr_0xFF");
            push(0, 1, 16'h0, (r == 0) ? "clr_0x7F" : "clr_wr_ignored_0x30");
            step();
            rd_en_a = '0;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); nm = nmq.pop_front();
                o = obs(int'(e.inst), int'(e.port));
                total++;
                if (o !== {1'b1, e.dat}) begin
                    bad++;
                    $display("FAIL %s: got valid=%b data=%h, want valid=1 data=%h", nm, o[16], o[15:0], e.dat);
                end
            end
        end
    endtask

    task automatic test_dual_read();
        exp_t e; string nm; logic [16:0] o;
        wr_en_a = 1'b1; wr_addr_a = 8'h10; wr_data_a = 8'hA5;
        step();
        wr_en_a = 1'b0;
        rd_en_a = 2'b11; rd_addr_a = 16'h1010;
        push(0, 0, 16'h00A5, "dual_p0");
        push(0, 1, 16'h00A5, "dual_p1");
        step();
        rd_en_a = '0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); nm = nmq.pop_front();
            o = obs(int'(e.inst), int'(e.port));
            total++;
            if (o !== {1'b1, e.dat}) begin
                bad++;
                $display("FAIL %s: got valid=%b data=%h, want valid=1 data=%h", nm, o[16], o[15:0], e.dat);
            end
        end
    endtask

    task automatic test_rdw();
        exp_t e; string nm; logic [16:0] o;
        for (int c = 0; c < 3; c++) begin
            wr_en_a = (c < 2); wr_addr_a = 8'h20; wr_data_a = (c == 0) ? 8'h11 : 8'h22;
            wr_en_b = (c < 2); wr_addr_b = 8'h20; wr_data_b = (c == 0) ? 8'h11 : 8'h22;
            rd_en_a = (c > 0) ? 2'b01 : 2'b00; rd_addr_a = 16'h0020;
            rd_en_b = (c > 0) ? 2'b01 : 2'b00; rd_addr_b = 16'h0020;
            if (c == 1) begin
                push(0, 0, 16'h0022, "rdw_new");
                push(1, 0, 16'h0011, "rdw_old");
            end else if (c == 2) begin
                push(0, 0, 16'h0022, "rdw_new_after");
                push(1, 0, 16'h0022, "rdw_old_after");
            end
            step();
            wr_en_a = 1'b0; wr_en_b = 1'b0; rd_en_a = '0; rd_en_b = '0;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); nm = nmq.pop_front();
                o = obs(int'(e.inst), int'(e.port));
                total++;
                if (o !== {1'b1, e.dat}) begin
                    bad++;
                    $display("FAIL %s: got valid=%b data=%h, want valid=1 data=%h", nm, o[16], o[15:0], e.dat);
                end
            end
        end
    endtask

    task automatic test_hold();
        exp_t e; string nm; logic [16:0] o;
        wr_en_a = 1'b1; wr_addr_a = 8'h40; wr_data_a = 8'h5C;
        step();
        wr_en_a = 1'b0;
        rd_en_a = 2'b10; rd_addr_a = 16'h4000;
        push(0, 1, 16'h005C, "hold_setup");
        step();
        rd_en_a = '0; rd_addr_a = 16'h1010;
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); nm = nmq.pop_front();
            o = obs(int'(e.inst), int'(e.port));
            total++;
            if (o !== {1'b1, e.dat}) begin
                bad++;
                $display("FAIL %s: got valid=%b data=%h, want valid=1 data=%h", nm, o[16], o[15:0], e.dat);
            end
        end
        step();
        total++;
        if (rd_valid_a[1] !== 1'b0 || rd_data_a[15:8] !== 8'h5C) begin
            bad++;
            $display("FAIL hold_p1: valid=%b data=%h, want valid=0 data=5c", rd_valid_a[1], rd_data_a[15:8]);
        end
        total++;
        if (rd_valid_a[0] !== 1'b0 || rd_data_a[7:0] !== 8'h22) begin
            bad++;
            $display("FAIL hold_p0: valid=%b data=%h, want valid=0 data=22", rd_valid_a[0], rd_data_a[7:0]);
        end
    endtask

    task automatic test_wide();
        exp_t e; string nm; logic [16:0] o;
        wr_en_c = 1'b1; wr_addr_c = 4'hF; wr_data_c = 16'hBEEF;
        step();
        wr_en_c = 1'b0;
        rd_en_c = 4'hF; rd_addr_c = 16'h1F0F;
        push(2, 0, 16'hBEEF, "wide_p0_0xF");
        push(2, 1, 16'h0000, "wide_p1_0x0");
        push(2, 2, 16'hBEEF, "wide_p2_0xF");
        push(2, 3, 16'h0000, "wide_p3_0x1");
        step();
        rd_en_c = '0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); nm = nmq.pop_front();
            o = obs(int'(e.inst), int'(e.port));
            total++;
            if (o !== {1'b1, e.dat}) begin
                bad++;
                $display("FAIL %s: got valid=%b data=%h, want valid=1 data=%h", nm, o[16], o[15:0], e.dat);
            end
        end
    endtask

    task automatic test_no_clear();
        exp_t e; string nm; logic [16:0] o;
        wr_en_d = 1'b1; wr_addr_d = 4'h5; wr_data_d = 8'h3C;
        step();
        wr_en_d = 1'b0;
        rd_en_d = 1'b1; rd_addr_d = 4'h5;
        push(3, 0, 16'h003C, "noclear_rw");
        step();
        rd_en_d = '0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); nm = nmq.pop_front();
            o = obs(int'(e.inst), int'(e.port));
            total++;
            if (o !== {1'b1, e.dat}) begin
                bad++;
                $display("FAIL %s: got valid=%b data=%h, want valid=1 data=%h", nm, o[16], o[15:0], e.dat);
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e; string nm; logic [16:0] o;
        int   n_rdy = -1;
        logic early = 1'b0;
        wr_en_a = 1'b1; wr_addr_a = 8'h50; wr_data_a = 8'h99;
        step();
        wr_en_a = 1'b0;
        rd_en_a = 2'b01; rd_addr_a = 16'h0050;
        push(0, 0, 16'h0099, "midrst_setup");
        step();
        rd_en_a = '0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); nm = nmq.pop_front();
            o = obs(int'(e.inst), int'(e.port));
            total++;
            if (o !== {1'b1, e.dat}) begin
                bad++;
                $display("FAIL %s: got valid=%b data=%h, want valid=1 data=%h", nm, o[16], o[15:0], e.dat);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (rd_data_a !== 16'h0 || rd_valid_a !== 2'b00 || ready_a !== 1'b0) begin
            bad++;
            $display("FAIL run_reset: data=%h valid=%b ready=%b, want 0000 00 0", rd_data_a, rd_valid_a, ready_a);
        end
        step();
        rst_n = 1'b1;
        for (int n = 0; n < 100; n++) begin
            step();
            if (ready_a !== 1'b0) early = 1'b1;
        end
        total++;
        if (early !== 1'b0) begin bad++; $display("FAIL sweep_ready_early: ready seen=%b, want 0", early); end
        rst_n = 1'b0;
        #1;
        total++;
        if (rd_data_a !== 16'h0 || rd_valid_a !== 2'b00 || ready_a !== 1'b0) begin
            bad++;
            $display("FAIL sweep_reset: data=%h valid=%b ready=%b, want 0000 00 0", rd_data_a, rd_valid_a, ready_a);
        end
        step();
        rst_n = 1'b1;
        for (int n = 1; n <= 300 && n_rdy < 0; n++) begin
            step();
            if (ready_a === 1'b1) n_rdy = n;
        end
        total++;
        if (n_rdy !== 256) begin bad++; $display("FAIL resweep_len: ready after %0d edges, want 256", n_rdy); end
        rd_en_a = 2'b11; rd_addr_a = 16'h1050;
        push(0, 0, 16'h0000, "resweep_0x50");
        push(0, 1, 16'h0000, "resweep_0x10");
        step();
        rd_en_a = '0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); nm = nmq.pop_front();
            o = obs(int'(e.inst), int'(e.port));
            total++;
            if (o !== {1'b1, e.dat}) begin
                bad++;
                $display("FAIL %s: got valid=%b data=%h, want valid=1 data=%h", nm, o[16], o[15:0], e.dat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear_reads();
        test_dual_read();
        test_rdw();
        test_hold();
        test_wide();
        test_no_clear();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
